// File: rtl/ad7928_spi_emulator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ad7928_spi_emulator : SPI slave that mimics an AD7928 8-channel, 12-bit ADC
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module ad7928_spi_emulator #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] RST_ADDR    = 3'd0
) (
  input  logic        clk_50m,
  input  logic        rstn,
  input  logic        spi_ss,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic [95:0] ch_data_i,
  output logic [11:0] ctrl_word_o,
  output logic [2:0]  cur_addr_o,
  output logic        frame_done_o,
  output logic        frame_err_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    OVERRUN = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   ss_prev_q, sck_prev_q;

  state_t      state_q, state_d;
  logic [15:0] tx_sr_q, tx_sr_d;
  logic [15:0] rx_sr_q, rx_sr_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] ctrl_word_q, ctrl_word_d;
  logic [2:0]  cur_addr_q, cur_addr_d;
  logic        miso_q, miso_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        ss_s, sck_s, mosi_s;
  logic        ss_fall, ss_rise, sck_fall;
  logic [11:0] ch_sel;

  generate
    if (SYNC_STAGES > 1) begin : g_sync_multi
      assign ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss};
      assign sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end else begin : g_sync_single
      assign ss_sync_d   = spi_ss;
      assign sck_sync_d  = spi_sck;
      assign mosi_sync_d = spi_mosi;
    end
  endgenerate

  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ss_fall  = ss_prev_q & ~ss_s;
  assign ss_rise  = ~ss_prev_q & ss_s;
  assign sck_fall = sck_prev_q & ~sck_s;

  always_comb begin
    ch_sel = 12'h000;
    for (int n = 0; n < 8; n++) begin
      if (cur_addr_q == 3'(n)) ch_sel = ch_data_i[12*n +: 12];
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    ctrl_word_d = ctrl_word_q;
    cur_addr_d  = cur_addr_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    // A rise in IDLE never had a matching fall, so it is not a frame.
    if (ss_rise) begin
      state_d = IDLE;
      if (state_q == SHIFT && bit_cnt_q == 5'd16) begin
        done_d = 1'b1;
        if (rx_sr_q[15]) begin
          ctrl_word_d = rx_sr_q[15:4];
          cur_addr_d  = rx_sr_q[12:10];
        end
      end else if (state_q != IDLE) begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            tx_sr_d   = {1'b0, cur_addr_q, ch_sel};
            rx_sr_d   = 16'h0000;
            bit_cnt_d = 5'd0;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          if (sck_fall && !ss_s) begin
            if (bit_cnt_q == 5'd16) begin
              state_d = OVERRUN;
            end else begin
              rx_sr_d   = {rx_sr_q[14:0], mosi_s};
              tx_sr_d   = {tx_sr_q[14:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end

    miso_d = (state_d == SHIFT) ? tx_sr_d[15] : 1'b0;
  end

  always_ff @(posedge clk_50m or negedge rstn) begin
    if (!rstn) begin
      ss_sync_q   <= '1;
      sck_sync_q  <= '1;
      mosi_sync_q <= '0;
      ss_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b1;
      state_q     <= IDLE;
      tx_sr_q     <= 16'h0000;
      rx_sr_q     <= 16'h0000;
      bit_cnt_q   <= 5'd0;
      ctrl_word_q <= 12'h000;
      cur_addr_q  <= RST_ADDR;
      miso_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ss_sync_q   <= ss_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_prev_q   <= ss_s;
      sck_prev_q  <= sck_s;
      state_q     <= state_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      ctrl_word_q <= ctrl_word_d;
      cur_addr_q  <= cur_addr_d;
      miso_q      <= miso_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign spi_miso     = miso_q;
  assign ctrl_word_o  = ctrl_word_q;
  assign cur_addr_o   = cur_addr_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;

endmodule
`default_nettype wire
